// File: rtl/dctn_engine.sv
// dctn_engine: two-pass separable N x N transform engine computing Y = C*X*C^T.
// Pass 1 builds T = X*C^T into an internal buffer; pass 2 streams out Y = C*T.
// Optional feature macro: DCTN_INVERSE_EN (inv=1 addresses C transposed, giving C^T*Y*C).
module dctn_engine #(
  parameter int unsigned N    = 8,
  parameter int unsigned DW   = 16,
  parameter int unsigned CW   = 16,
  parameter int unsigned FRAC = 14,
  parameter int unsigned OW   = 16,
  parameter int unsigned AW   = 2 * $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          inv,
  output logic          rdy,
  output logic [AW-1:0] iaddr,
  input  logic [DW-1:0] iq,
  output logic [AW-1:0] maddr,
  input  logic [CW-1:0] mq,
  output logic [AW-1:0] waddr,
  output logic [OW-1:0] wdata,
  output logic          wwren
);

  localparam int unsigned LN  = $clog2(N);
  localparam int unsigned PW  = DW + CW;
  localparam int unsigned ACW = PW + LN;
  // One guard bit so the rounding add can never wrap.
  localparam int unsigned RW  = ACW + 1;

  localparam logic [AW-1:0] LastElem = AW'(N * N - 1);
  localparam logic [LN-1:0] LastTap  = LN'(N - 1);

  localparam logic signed [RW-1:0] SatMax = RW'((longint'(1) <<< (OW - 1)) - 1);
  localparam logic signed [RW-1:0] SatMin = ~SatMax;
  localparam logic signed [RW-1:0] RndK   = RW'(longint'(1) <<< (FRAC - 1));

  typedef enum logic [1:0] {StIdle, StPass1, StPass2, StFlush} state_e;

  state_e state_q, state_d;

  // Issue stage: element / tap counters drive the read addresses.
  logic [LN-1:0] tap_q, tap_d;
  logic [AW-1:0] elem_q, elem_d;
  logic          iss_done_q, iss_done_d;
  logic          inv_q, inv_d;

  // MAC stage: operands arrive one cycle after their addresses were issued.
  logic          s1_valid_q, s1_valid_d;
  logic          s1_first_q, s1_first_d;
  logic          s1_last_q, s1_last_d;
  logic          s1_pass2_q, s1_pass2_d;
  logic [AW-1:0] s1_elem_q, s1_elem_d;
  logic [OW-1:0] t_q, t_d;
  logic signed [ACW-1:0] acc_q, acc_d;

  // Output write stage.
  logic          wwren_q, wwren_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [OW-1:0] wdata_q, wdata_d;

  // Intermediate T buffer; contents need no reset.
  logic [OW-1:0] tbuf [N*N];

  logic          issue;
  logic          last_issue;
  logic          buf_we;
  logic [LN-1:0] row;
  logic [LN-1:0] col;
  logic [AW-1:0] t_raddr;

  logic signed [DW-1:0]  op_a;
  logic signed [PW-1:0]  prod;
  logic signed [ACW-1:0] acc_base;
  logic signed [ACW-1:0] acc_sum;
  logic signed [RW-1:0]  rnd;
  logic signed [RW-1:0]  shr;
  logic [OW-1:0]         res_sat;

`ifndef DCTN_INVERSE_EN
  logic unused_inv;
  assign unused_inv = inv;
`endif

  // Address generation and MAC/round/saturate datapath.
  always_comb begin
    row     = elem_q[AW-1:LN];
    col     = elem_q[LN-1:0];
    iaddr   = {row, tap_q};
    t_raddr = {tap_q, col};
    if (state_q == StPass2) begin
      maddr = inv_q ? {tap_q, row} : {row, tap_q};
    end else begin
      maddr = inv_q ? {tap_q, col} : {col, tap_q};
    end

    op_a     = s1_pass2_q ? DW'($signed(t_q)) : $signed(iq);
    prod     = PW'(op_a) * PW'($signed(mq));
    acc_base = s1_first_q ? '0 : acc_q;
    acc_sum  = acc_base + ACW'(prod);
    rnd      = RW'(acc_sum) + RndK;
    shr      = rnd >>> FRAC;
    if (shr > SatMax) begin
      res_sat = SatMax[OW-1:0];
    end else if (shr < SatMin) begin
      res_sat = SatMin[OW-1:0];
    end else begin
      res_sat = shr[OW-1:0];
    end
  end

  // Next-state logic for the FSM, counters and pipeline stages.
  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    elem_d     = elem_q;
    iss_done_d = iss_done_q;
    inv_d      = inv_q;
    acc_d      = acc_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    issue      = ((state_q == StPass1) && !iss_done_q) || (state_q == StPass2);
    last_issue = issue && (tap_q == LastTap) && (elem_q == LastElem);

    if (issue) begin
      tap_d = tap_q + LN'(1);
      if (tap_q == LastTap) begin
        elem_d = elem_q + AW'(1);
      end
    end

    s1_valid_d = issue;
    s1_first_d = (tap_q == '0);
    s1_last_d  = (tap_q == LastTap);
    s1_pass2_d = (state_q == StPass2);
    s1_elem_d  = elem_q;
    t_d        = tbuf[t_raddr];

    if (s1_valid_q) begin
      acc_d = acc_sum;
    end

    buf_we  = s1_valid_q && s1_last_q && !s1_pass2_q;
    wwren_d = s1_valid_q && s1_last_q && s1_pass2_q;
    if (wwren_d) begin
      waddr_d = s1_elem_q;
      wdata_d = res_sat;
    end

    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d    = StPass1;
          iss_done_d = 1'b0;
`ifdef DCTN_INVERSE_EN
          inv_d      = inv;
`else
          inv_d      = 1'b0;
`endif
        end
      end
      StPass1: begin
        if (last_issue) begin
          iss_done_d = 1'b1;
        end
        // Pass 2 reads T, so wait until the final T element has landed.
        if (buf_we && (s1_elem_q == LastElem)) begin
          state_d = StPass2;
        end
      end
      StPass2: begin
        if (last_issue) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (wwren_q && (waddr_q == LastElem)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      tap_q      <= '0;
      elem_q     <= '0;
      iss_done_q <= 1'b0;
      inv_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_pass2_q <= 1'b0;
      s1_elem_q  <= '0;
      t_q        <= '0;
      acc_q      <= '0;
      wwren_q    <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      tap_q      <= tap_d;
      elem_q     <= elem_d;
      iss_done_q <= iss_done_d;
      inv_q      <= inv_d;
      s1_valid_q <= s1_valid_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_pass2_q <= s1_pass2_d;
      s1_elem_q  <= s1_elem_d;
      t_q        <= t_d;
      acc_q      <= acc_d;
      wwren_q    <= wwren_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Store finished pass-1 elements into the T buffer.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      tbuf[s1_elem_q] <= res_sat;
    end
  end

  assign rdy   = (state_q == StIdle);
  assign wwren = wwren_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;

endmodule

// File: tb/tb_dctn_engine.sv
// Self-checking bench for dctn_engine: table of transform cases on N=8 and N=4 instances,
// a reference model feeding a write scoreboard, plus handshake and mid-run abort sequences.
module tb_dctn_engine;

  localparam int Limit = 6000;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        en8 = 1'b0, inv8 = 1'b0, rdy8, wwren8;
  logic [5:0]  iaddr8, maddr8, waddr8;
  logic [15:0] iq8, mq8, wdata8;
  logic        en4 = 1'b0, inv4 = 1'b0, rdy4, wwren4;
  logic [3:0]  iaddr4, maddr4, waddr4;
  logic [15:0] iq4, mq4, wdata4;

  dctn_engine #(.N(8)) u_dut8 (
    .clk(clk), .reset(reset), .en(en8), .inv(inv8), .rdy(rdy8),
    .iaddr(iaddr8), .iq(iq8), .maddr(maddr8), .mq(mq8),
    .waddr(waddr8), .wdata(wdata8), .wwren(wwren8)
  );

  dctn_engine #(.N(4), .AW(4)) u_dut4 (
    .clk(clk), .reset(reset), .en(en4), .inv(inv4), .rdy(rdy4),
    .iaddr(iaddr4), .iq(iq4), .maddr(maddr4), .mq(mq4),
    .waddr(waddr4), .wdata(wdata4), .wwren(wwren4)
  );

  logic [15:0] x8 [64];
  logic [15:0] c8 [64];
  logic [15:0] x4 [16];
  logic [15:0] c4 [16];

  // Synchronous memories with one-cycle read latency.
  always @(posedge clk) begin
    iq8 <= x8[iaddr8];
    mq8 <= c8[maddr8];
    iq4 <= x4[iaddr4];
    mq4 <= c4[maddr4];
  end

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t q8[$];
  exp_t q4[$];
  exp_t mon8_e, mon4_e;
  int   ycap8 [64];
  int   ycap4 [16];
  int   nwr8 = 0, nwr4 = 0;
  int   checks = 0, errors = 0;

  int xm [64];
  int cm [64];
  int tm [64];
  int ym [64];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard for the N=8 instance.
  always @(negedge clk) begin
    if (wwren8) begin
      chk("n8_write_while_busy", rdy8, 0);
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL n8_unexpected_write: addr %0d data %0d, expected no write",
                 waddr8, $signed(wdata8));
      end else begin
        mon8_e = q8.pop_front();
        chk("n8_waddr", waddr8, mon8_e.addr);
        chk("n8_wdata", $signed(wdata8), mon8_e.data);
      end
      ycap8[waddr8] = $signed(wdata8);
      nwr8++;
    end
  end

  // Scoreboard for the N=4 instance.
  always @(negedge clk) begin
    if (wwren4) begin
      chk("n4_write_while_busy", rdy4, 0);
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL n4_unexpected_write: addr %0d data %0d, expected no write",
                 waddr4, $signed(wdata4));
      end else begin
        mon4_e = q4.pop_front();
        chk("n4_waddr", waddr4, mon4_e.addr);
        chk("n4_wdata", $signed(wdata4), mon4_e.data);
      end
      ycap4[waddr4] = $signed(wdata4);
      nwr4++;
    end
  end

  function automatic longint rs(input longint a);
    longint s;
    s = (a + 8192) >>> 14;
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    return s;
  endfunction

  // Reference: T[r][k] = sum X[r][n]*C[k][n]; Y[k][c] = sum C[k][r]*T[r][c]; inv transposes C.
  task automatic model(input int n, input bit inv_m);
    longint acc;
    int ci;
    for (int r = 0; r < n; r++)
      for (int k = 0; k < n; k++) begin
        acc = 0;
        for (int j = 0; j < n; j++) begin
          ci = inv_m ? j * n + k : k * n + j;
          acc += longint'(xm[r*n+j]) * longint'(cm[ci]);
        end
        tm[r*n+k] = int'(rs(acc));
      end
    for (int k = 0; k < n; k++)
      for (int c = 0; c < n; c++) begin
        acc = 0;
        for (int r = 0; r < n; r++) begin
          ci = inv_m ? r * n + k : k * n + r;
          acc += longint'(cm[ci]) * longint'(tm[r*n+c]);
        end
        ym[k*n+c] = int'(rs(acc));
      end
  endtask

  // cpat: 0 identity, 1 DCT Q14, 2 diag 32767, 3 cyclic shift.
  // xpat: 0 i-32, 1 all 16, 2 all 0x7FFF, 3 all 0x8000, 4 i.
  task automatic setup(input int sel, input int cpat, input int xpat);
    int n;
    real v;
    n = (sel == 0) ? 8 : 4;
    for (int k = 0; k < n; k++)
      for (int j = 0; j < n; j++) begin
        case (cpat)
          0: cm[k*n+j] = (k == j) ? 16384 : 0;
          1: begin
            v = ((k == 0) ? $sqrt(1.0 / 8.0) : 0.5) *
                $cos(real'((2 * j + 1) * k) * 3.14159265358979 / 16.0) * 16384.0;
            cm[k*n+j] = (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
          end
          2: cm[k*n+j] = (k == j) ? 32767 : 0;
          default: cm[k*n+j] = (j == (k + 1) % n) ? 16384 : 0;
        endcase
      end
    for (int i = 0; i < n * n; i++) begin
      case (xpat)
        0: xm[i] = i - 32;
        1: xm[i] = 16;
        2: xm[i] = 32767;
        3: xm[i] = -32768;
        default: xm[i] = i;
      endcase
      if (sel == 0) begin
        x8[i] = 16'(xm[i]);
        c8[i] = 16'(cm[i]);
      end else begin
        x4[i] = 16'(xm[i]);
        c4[i] = 16'(cm[i]);
      end
    end
  endtask

  task automatic push(input int sel);
    exp_t e;
    int n;
    n = (sel == 0) ? 8 : 4;
    for (int i = 0; i < n * n; i++) begin
      e.addr = i;
      e.data = ym[i];
      if (sel == 0) q8.push_back(e);
      else q4.push_back(e);
    end
  endtask

  function automatic bit eff_inv(input bit v);
`ifdef DCTN_INVERSE_EN
    return v;
`else
    return 1'b0 & v;
`endif
  endfunction

  // One complete run: model, start with a one-cycle en pulse, wait for rdy, check counts.
  task automatic run_case(input int sel, input bit inv_v, output int busy);
    int n, base;
    n = (sel == 0) ? 8 : 4;
    model(n, eff_inv(inv_v));
    push(sel);
    for (int i = 0; i < 64; i++) ycap8[i] = 99999;
    for (int i = 0; i < 16; i++) ycap4[i] = 99999;
    base = (sel == 0) ? nwr8 : nwr4;
    @(negedge clk);
    chk("rdy_before_start", (sel == 0) ? rdy8 : rdy4, 1);
    if (sel == 0) begin en8 = 1'b1; inv8 = inv_v; end
    else begin en4 = 1'b1; inv4 = inv_v; end
    @(negedge clk);
    // Flip inv after acceptance; the run must keep the sampled value.
    if (sel == 0) begin en8 = 1'b0; inv8 = ~inv_v; end
    else begin en4 = 1'b0; inv4 = ~inv_v; end
    chk("rdy_low_after_accept", (sel == 0) ? rdy8 : rdy4, 0);
    busy = 0;
    while (!((sel == 0) ? rdy8 : rdy4) && busy < Limit) begin
      busy++;
      @(negedge clk);
    end
    chk("run_completes", (sel == 0) ? rdy8 : rdy4, 1);
    chk("busy_within_bound", busy <= 2 * n * n * (n + 1) + 4, 1);
    chk("write_count", ((sel == 0) ? nwr8 : nwr4) - base, n * n);
    chk("pending_results", (sel == 0) ? q8.size() : q4.size(), 0);
  endtask

  typedef struct {
    int sel;
    int cpat;
    int xpat;
    bit inv;
    int exp_first;
    int exp_last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int busy, starts, hi, cyc, cnt, base;

    vecs[0] = '{sel: 0, cpat: 0, xpat: 0, inv: 1'b0, exp_first: -32, exp_last: 31};
    vecs[1] = '{sel: 0, cpat: 1, xpat: 1, inv: 1'b0, exp_first: 127, exp_last: 0};
    vecs[2] = '{sel: 0, cpat: 2, xpat: 2, inv: 1'b0, exp_first: 32767, exp_last: 32767};
    vecs[3] = '{sel: 0, cpat: 2, xpat: 3, inv: 1'b0, exp_first: -32768, exp_last: -32768};
    vecs[4] = '{sel: 1, cpat: 3, xpat: 4, inv: 1'b0, exp_first: 5, exp_last: 0};
`ifdef DCTN_INVERSE_EN
    vecs[5] = '{sel: 1, cpat: 3, xpat: 4, inv: 1'b1, exp_first: 15, exp_last: 10};
`else
    vecs[5] = '{sel: 1, cpat: 3, xpat: 4, inv: 1'b1, exp_first: 5, exp_last: 0};
`endif

    for (int i = 0; i < 64; i++) begin x8[i] = '0; c8[i] = '0; end
    for (int i = 0; i < 16; i++) begin x4[i] = '0; c4[i] = '0; end

    // Reset for one cycle, then idle state and quiet outputs.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_rdy", rdy8, 1);
    chk("reset_wwren", wwren8, 0);
    chk("reset_waddr", waddr8, 0);
    chk("reset_wdata", wdata8, 0);
    chk("reset_iaddr", iaddr8, 0);
    chk("reset_maddr", maddr8, 0);
    chk("reset_n4_rdy", rdy4, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_no_write", wwren8 | wwren4, 0);
    end

    // Table-driven transform cases.
    for (int v = 0; v < 6; v++) begin
      setup(vecs[v].sel, vecs[v].cpat, vecs[v].xpat);
      run_case(vecs[v].sel, vecs[v].inv, busy);
      if (vecs[v].sel == 0) begin
        chk("table_y_first", ycap8[0], vecs[v].exp_first);
        chk("table_y_last", ycap8[63], vecs[v].exp_last);
      end else begin
        chk("table_n4_y_first", ycap4[0], vecs[v].exp_first);
        chk("table_n4_y_last", ycap4[15], vecs[v].exp_last);
      end
    end

    // en held high across three back-to-back runs.
    setup(0, 0, 0);
    model(8, 1'b0);
    push(0);
    push(0);
    push(0);
    base = nwr8;
    starts = 0;
    hi = 0;
    cyc = 0;
    @(negedge clk);
    en8 = 1'b1;
    while (starts < 3 && cyc < 3 * Limit) begin
      if (rdy8) begin
        hi++;
        if (hi == 1) starts++;
      end else begin
        if (hi != 0 && starts >= 2) chk("held_en_rdy_gap", hi, 1);
        hi = 0;
      end
      if (starts < 3) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("held_en_starts", starts, 3);
    @(negedge clk);
    en8 = 1'b0;
    chk("held_en_third_gap", rdy8, 0);
    cyc = 0;
    while (!rdy8 && cyc < Limit) begin
      @(negedge clk);
      cyc++;
    end
    chk("held_en_done", rdy8, 1);
    chk("held_en_writes", nwr8 - base, 192);
    chk("held_en_pending", q8.size(), 0);

    // Abort with reset on the 5th write, then a clean rerun.
    setup(0, 0, 0);
    model(8, 1'b0);
    push(0);
    @(negedge clk);
    en8 = 1'b1;
    @(negedge clk);
    en8 = 1'b0;
    cnt = 0;
    cyc = 0;
    while (cnt < 5 && cyc < Limit) begin
      @(negedge clk);
      cyc++;
      if (wwren8) cnt++;
    end
    chk("abort_fifth_write_seen", cnt, 5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_rdy", rdy8, 1);
    chk("abort_wwren", wwren8, 0);
    chk("abort_waddr", waddr8, 0);
    chk("abort_wdata", wdata8, 0);
    q8.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("abort_no_more_writes", wwren8, 0);
    end
    run_case(0, 1'b0, busy);
    chk("rerun_y_first", ycap8[0], -32);
    chk("rerun_y_mid", ycap8[37], 5);
    chk("rerun_y_last", ycap8[63], 31);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dctn_engine.md
DCTN_ENGINE -- requirements
Module: dctn_engine

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- N, 8: block size; legal values 4 and 8.
- DW, 16: signed input sample width.
- CW, 16: signed coefficient width.
- FRAC, 14: coefficient fraction bits.
- OW, 16: signed output width; also the width of the intermediate buffer.
- AW, 2*log2(N): address width.

REQ-002 The block SHALL have these ports (name, direction, width, meaning); one clock, reset synchronous and active-high:
- clk, in, 1: sole clock, rising edge.
- reset, in, 1: synchronous active-high reset.
- en, in, 1: start request.
- inv, in, 1: inverse-transform select.
- rdy, out, 1: idle and able to accept en.
- iaddr, out, AW: input sample address, row-major.
- iq, in, DW: input sample, one-cycle read latency.
- maddr, out, AW: coefficient address, row-major C[k][n].
- mq, in, CW: coefficient, one-cycle read latency.
- waddr, out, AW: output address.
- wdata, out, OW: output value.
- wwren, out, 1: output write strobe.

Function
REQ-003 The block SHALL compute Y = C*X*C^T; the external memories hold X (N*N samples) and C (N*N coefficients).
REQ-004 Read timing SHALL be as follows: data for an iaddr or maddr driven in cycle k is valid on iq or mq in cycle k+1.
REQ-005 The block SHALL implement states IDLE, PASS1, PASS2 and FLUSH:
- IDLE to PASS1 on en=1 while rdy=1.
- PASS1 to PASS2 after the last intermediate element is stored.
- PASS2 to FLUSH after the last MAC is issued.
- FLUSH to IDLE after the last write.
REQ-006 rdy SHALL be 1 only in IDLE and SHALL deassert the cycle after en is accepted.
REQ-007 en asserted outside IDLE SHALL be ignored.
REQ-008 en held high SHALL cause a new run to start in the first cycle rdy=1.
REQ-009 inv SHALL be sampled only at en acceptance and held for the run.
REQ-010 PASS1 SHALL compute T[r][k] = sum over n of X[r][n]*C[k][n] into an internal N*N buffer of OW-bit words.
REQ-011 PASS2 SHALL compute Y[k][c] = sum over r of C[k][r]*T[r][c].
REQ-012 Each element SHALL be exactly N MAC cycles, with no idle cycles between elements within a pass.
REQ-013 Products SHALL be DW+CW bits and accumulators DW+CW+log2(N) bits; in PASS2 the T operand is OW bits, sign-extended.
REQ-014 Each accumulated result SHALL be processed in this order: add 2^(FRAC-1), arithmetic shift right by FRAC, then saturate to the OW signed range.
REQ-015 Saturation SHALL clamp to 2^(OW-1)-1 and -2^(OW-1).
REQ-016 wwren SHALL pulse exactly once per output element, only in PASS2 or FLUSH.
REQ-017 waddr SHALL take each value 0..N*N-1 exactly once, in ascending row-major order.
REQ-018 wdata and waddr SHALL be valid only while wwren=1.
REQ-019 rdy SHALL rise the cycle after the final wwren pulse.
REQ-020 The busy period, from the cycle after en acceptance to rdy high, SHALL be at most 2*N*N*(N+1)+4 cycles.
REQ-021 The block SHALL never issue a write to any address outside 0..N*N-1.

Reset
REQ-022 With reset=1 at a rising edge, the next cycle SHALL show:
- state IDLE, rdy=1, wwren=0;
- iaddr, maddr and waddr = 0; wdata = 0.
REQ-023 Reset SHALL take effect in any state, aborting a run with no further wwren pulses; intermediate buffer contents are unspecified.
REQ-024 A run started after a mid-run reset SHALL produce results identical to those of a clean run.

Configuration
REQ-025 With macro DCTN_INVERSE_EN defined:
- inv=1 SHALL compute X' = C^T*Y*C by addressing C transposed (maddr = n*N+k instead of k*N+n) in both passes;
- inv=0 SHALL behave per REQ-010 and REQ-011.
REQ-026 With DCTN_INVERSE_EN undefined, the inv input SHALL be ignored and the block SHALL always perform the forward transform.

Verification
REQ-027 Reset: assert reset for 1 cycle -> rdy=1, wwren=0, waddr=0 the next cycle; no writes for 10 idle cycles.
REQ-028 Identity matrix: N=8, C = 16384 on the diagonal and 0 elsewhere, X[i] = i-32 -> Y[i] = i-32 exactly, 64 writes in order 0..63, busy period within the REQ-020 bound.
REQ-029 DC case: N=8, C = orthonormal DCT in Q14, X all 16 -> Y[0]=127, all other Y = 0.
REQ-030 Saturation: C diagonal 32767, X all 0x7FFF -> every diagonal-path output 0x7FFF; X all 0x8000 -> 0x8000.
REQ-031 Handshake and abort:
- en held high for 3 runs -> back-to-back runs, each rdy gap exactly 1 cycle;
- reset asserted on the 5th PASS2 write -> no further wwren, rdy=1 the next cycle, then a clean rerun matches the REQ-028 result.
REQ-032 Inverse and N=4: with DCTN_INVERSE_EN, N=4, C = cyclic shift matrix (16384 at [k][(k+1) mod 4]), X[i]=i:
- inv=1 result SHALL equal the transpose-addressed reference model bit-exactly;
- without the macro, inv=1 SHALL give the forward result.
